chinx_gpio_debounce: RTL

//  Input-side GPIO stage feeding CPU I/O port io0 from board switches. It syncs the raw pads, debounces each bit and

---
 rtl/chinx_pkg.sv | 14 +
 rtl/chinx_debounce_bit.sv | 84 ++++++++
 rtl/chinx_gpio_debounce.sv | 43 ++++
 3 files changed

// File: rtl/chinx_pkg.sv
// Shared constants for the chinx CPU I/O datapath.
package chinx_pkg;

  // Width of a CPU I/O port such as io0.
  localparam int IO_W = 8;

  // Divided system clock that the pipeline and its I/O stages run on.
  localparam int SYS_CLK_HZ = 500_000;

  // Switch settle time and the equivalent number of system clock cycles.
  localparam int DEBOUNCE_MS     = 10;
  localparam int DEBOUNCE_CYCLES = (SYS_CLK_HZ / 1000) * DEBOUNCE_MS;

endpackage

// File: rtl/chinx_debounce_bit.sv
// One switch bit: two-flop synchronizer, debounce counter, accepted level,
// registered rise/fall pulses and a sticky change flag.
module chinx_debounce_bit #(
  parameter int DEBOUNCE_CYCLES = chinx_pkg::DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic pad_i,
  input  logic chg_clr_i,
  output logic stable_o,
  output logic rise_o,
  output logic fall_o,
  output logic chg_o
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q, s2_q;
  logic             stable_q, stable_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             chg_q, chg_d;
  logic             accept;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count consecutive cycles the synchronized level differs from the accepted one.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    cnt_d    = '0;
    stable_d = stable_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    accept   = 1'b0;
    if (s2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        accept   = 1'b1;
        stable_d = s2_q;
        rise_d   = s2_q;
        fall_d   = ~s2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    // A new acceptance outranks a clear arriving in the same cycle.
    if (accept) begin
      chg_d = 1'b1;
    end else if (chg_clr_i) begin
      chg_d = 1'b0;
    end else begin
      chg_d = chg_q;
    end
  end

  // Synchronizer and debounce state; reset overrides any acceptance or clear.
  always_ff @(posedge clk) begin
    // NOTE: state flops use non-blocking assignment so s2_q picks up the old
    // s1_q, giving a true two-stage pipeline instead of a single flop.
    if (rst) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      chg_q    <= 1'b0;
    end else begin
      s1_q     <= pad_i;
      s2_q     <= s1_q;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      chg_q    <= chg_d;
    end
  end

  assign stable_o = stable_q;
  assign rise_o   = rise_q;
  assign fall_o   = fall_q;
  assign chg_o    = chg_q;

endmodule

// File: rtl/chinx_gpio_debounce.sv
// GPIO input stage for CPU port io0: debounces WIDTH board switches and
// presents them zero-extended to the CPU port width, with edge pulses and
// sticky change flags.
module chinx_gpio_debounce
  import chinx_pkg::*;
#(
  parameter int WIDTH           = 3,
  parameter int DEBOUNCE_CYCLES = chinx_pkg::DEBOUNCE_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pad_i,
  output logic [IO_W-1:0]  io_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic [WIDTH-1:0] chg_o,
  input  logic [WIDTH-1:0] chg_clr_i
);

  logic [WIDTH-1:0] stable;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    chinx_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk      (clk),
      .rst      (rst),
      .pad_i    (pad_i[i]),
      .chg_clr_i(chg_clr_i[i]),
      .stable_o (stable[i]),
      .rise_o   (rise_o[i]),
      .fall_o   (fall_o[i]),
      .chg_o    (chg_o[i])
    );
  end

  // Zero-extend the registered stable levels to the CPU port width.
  always_comb begin
    io_o              = '0;
    io_o[WIDTH-1:0]   = stable;
  end

endmodule
